// File: rtl/dcache_port_arbiter_pkg.sv
// rtl/dcache_port_arbiter_pkg.sv - dcache CPU port request/response structs
package dcache_port_arbiter_pkg;

  typedef struct packed {
    logic [11:0] address_index;
    logic [19:0] address_tag;
    logic [63:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [7:0]  data_be;
    logic [1:0]  data_size;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

endpackage

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - round-robin sharing of one dcache CPU port among NR_REQ requesters
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ          = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  dcache_req_i_t                      req_ports_i [NR_REQ],
  output dcache_req_o_t                      req_ports_o [NR_REQ],
  output dcache_req_i_t                      dcache_req_o,
  input  dcache_req_o_t                      dcache_rsp_i,
  output logic                               busy_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);

  localparam int unsigned IDW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {IDLE, REQ, TAG} state_e;

  state_e         state_q;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              gnt;
  logic              req_en;
  logic              pick_valid;
  logic [IDW-1:0]    pick;
  logic [IDW-1:0]    head;
  logic [NR_REQ-1:0] sel;
  dcache_req_i_t     owner_req;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v, input int unsigned k);
    int unsigned s;
    s = (32'(v) + k) % NR_REQ;
    return IDW'(s);
  endfunction

  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];
  assign owner_req  = req_ports_i[owner_q];

  // Reads need a free ID slot to be selectable; writes never touch the FIFO.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      sel[i] = req_ports_i[i].data_req && (req_ports_i[i].data_we || !fifo_full);
    end
  end

  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      if (!pick_valid && sel[wrap_inc(rr_q, k)]) begin
        pick_valid = 1'b1;
        pick       = wrap_inc(rr_q, k);
      end
    end
  end

  assign req_en = owner_req.data_req && (owner_req.data_we || !fifo_full);
  assign gnt    = (state_q == REQ) && req_en && dcache_rsp_i.data_gnt;
  assign push   = gnt && !owner_req.data_we;
  assign pop    = dcache_rsp_i.data_rvalid && !fifo_empty;

  always_comb begin
    dcache_req_o = '0;
    case (state_q)
      REQ: begin
        dcache_req_o          = owner_req;
        dcache_req_o.data_req = req_en;
      end
      TAG: begin
        dcache_req_o.address_tag = owner_req.address_tag;
        dcache_req_o.tag_valid   = owner_req.tag_valid;
        dcache_req_o.kill_req    = owner_req.kill_req;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      req_ports_o[i] = '0;
      if (owner_q == IDW'(i)) begin
        req_ports_o[i].data_gnt = gnt;
      end
      if (pop && head == IDW'(i)) begin
        req_ports_o[i].data_rvalid = 1'b1;
        req_ports_o[i].data_rdata  = dcache_rsp_i.data_rdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick;
            state_q <= REQ;
          end
        end
        REQ: begin
          // An abandoned request leaves the round-robin pointer where it was.
          if (!owner_req.data_req) begin
            state_q <= IDLE;
          end else if (gnt) begin
            rr_q    <= wrap_inc(owner_q, 1);
            state_q <= owner_req.data_we ? IDLE : TAG;
          end
        end
        TAG:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (push) begin
        fifo_q[wr_ptr_q] <= owner_q;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign busy_o        = (state_q != IDLE) || !fifo_empty;
  assign outstanding_o = count_q;

endmodule
